// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (I) and data
//   access (D). One transaction is in flight at a time. The winner's request
//   is latched into the m_* registers while idle and is then held on the
//   shared port until m_ack. The completion is routed back combinationally.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests alternate, and the side that was not
//                 granted last wins
//     undefined : fixed priority, D always beats I
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction; sample i_req/d_req and latch the winner
//   GRANT_I | fetch owns the shared port, m_req held until m_ack
//   GRANT_D | data access owns the shared port, m_req held until m_ack

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_ack,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_ack,
    output logic                      m_req,
    output logic                      m_we,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_be,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic                      m_ack,
    output logic                      grant_sel,
    output logic                      busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // 0 = I was granted last, 1 = D was granted last
    logic   last_grant;
    logic   last_grant_nxt;
    logic   d_wins;

    // Arbitration: decides whether D takes the port when sampled in IDLE
`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        d_wins = d_req & (~i_req | ~last_grant);
    end
`else
    always_comb begin
        d_wins = d_req;
    end
`endif

    // Next-state and last-grant bookkeeping
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (d_wins) begin
                    state_nxt      = GRANT_D;
                    last_grant_nxt = 1'b1;
                end else if (i_req) begin
                    state_nxt      = GRANT_I;
                    last_grant_nxt = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (m_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Shared-port request registers, loaded only when a grant is issued so
    // a requester dropping req mid-transaction cannot disturb the port
    always_ff @(posedge clk) begin
        if (rst) begin
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
        end else if (state == IDLE) begin
            if (d_wins) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
            end else if (i_req) begin
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
                m_be    <= {BE_WIDTH{1'b1}};
            end
        end
    end

    // Port request, status and completion routing back to the owner
    always_comb begin
        m_req     = (state != IDLE);
        busy      = (state != IDLE);
        grant_sel = (state == GRANT_D);
        i_ack     = (state == GRANT_I) & m_ack;
        d_ack     = (state == GRANT_D) & m_ack;
        i_rdata   = i_ack ? m_rdata : '0;
        d_rdata   = d_ack ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed vector table, hand-written contest/reset sequences, and a
//   randomized run checked against a transaction-level reference model.
//   Honours ARB_ROUND_ROBIN_EN to select the expected arbitration policy.

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          grant_sel;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .grant_sel (grant_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [BW-1:0] d_be;
        logic          m_ack;
        logic [DW-1:0] m_rdata;
        logic          e_m_req;
        logic          e_m_we;
        logic [AW-1:0] e_m_addr;
        logic [DW-1:0] e_m_wdata;
        logic [BW-1:0] e_m_be;
        logic          e_i_ack;
        logic [DW-1:0] e_i_rdata;
        logic          e_d_ack;
        logic [DW-1:0] e_d_rdata;
        logic          e_busy;
        logic          e_gsel;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dwe, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, input logic [BW-1:0] dbe,
                         input logic ma, input logic [DW-1:0] mrd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_be    = dbe;
        m_ack   = ma;
        m_rdata = mrd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic ir, input logic [AW-1:0] ia,
        input logic dr, input logic dwe, input logic [AW-1:0] da,
        input logic [DW-1:0] dwd, input logic [BW-1:0] dbe,
        input logic ma, input logic [DW-1:0] mrd,
        input logic emr, input logic emwe, input logic [AW-1:0] ema,
        input logic [DW-1:0] emwd, input logic [BW-1:0] embe,
        input logic eia, input logic [DW-1:0] eird,
        input logic eda, input logic [DW-1:0] edrd,
        input logic eb, input logic egs);
        vec_t v;
        v.i_req = ir;  v.i_addr = ia;
        v.d_req = dr;  v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd; v.d_be = dbe;
        v.m_ack = ma;  v.m_rdata = mrd;
        v.e_m_req = emr; v.e_m_we = emwe; v.e_m_addr = ema; v.e_m_wdata = emwd; v.e_m_be = embe;
        v.e_i_ack = eia; v.e_i_rdata = eird; v.e_d_ack = eda; v.e_d_rdata = edrd;
        v.e_busy = eb; v.e_gsel = egs;
        return v;
    endfunction

    // Reference model: one pending transaction record plus last winner
    logic          mdl_busy;
    logic          mdl_own_d;
    logic          mdl_we;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    logic [BW-1:0] mdl_be;
    logic          mdl_last_d;

    task automatic mdl_step();
        logic win_d;
        if (rst) begin
            mdl_busy   = 1'b0;
            mdl_last_d = 1'b0;
        end else if (mdl_busy) begin
            if (m_ack) mdl_busy = 1'b0;
        end else if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = d_req && (!i_req || !mdl_last_d);
`else
            win_d = d_req;
`endif
            mdl_busy   = 1'b1;
            mdl_own_d  = win_d;
            mdl_last_d = win_d;
            if (win_d) begin
                mdl_we = d_we; mdl_addr = d_addr; mdl_wdata = d_wdata; mdl_be = d_be;
            end else begin
                mdl_we = 1'b0; mdl_addr = i_addr; mdl_wdata = '0; mdl_be = '1;
            end
        end
    endtask

    task automatic mdl_check();
        logic ea_i;
        logic ea_d;
        ea_i = mdl_busy && !mdl_own_d && m_ack;
        ea_d = mdl_busy &&  mdl_own_d && m_ack;
        chk("rnd_busy",  busy,  mdl_busy);
        chk("rnd_m_req", m_req, mdl_busy);
        chk("rnd_i_ack", i_ack, ea_i);
        chk("rnd_d_ack", d_ack, ea_d);
        chk("rnd_i_rdata", i_rdata, ea_i ? m_rdata : 32'h0);
        chk("rnd_d_rdata", d_rdata, ea_d ? m_rdata : 32'h0);
        if (mdl_busy) begin
            chk("rnd_gsel",    grant_sel, mdl_own_d);
            chk("rnd_m_we",    m_we,      mdl_we);
            chk("rnd_m_addr",  m_addr,    mdl_addr);
            chk("rnd_m_wdata", m_wdata,   mdl_wdata);
            chk("rnd_m_be",    m_be,      mdl_be);
        end
    endtask

    initial begin
        logic exp_d [4];
        logic rnd_req_i;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed vectors: single fetch, held data write, request drop, idle m_ack
        vecs[0]  = mk(1,32'h100,0,0,0,0,0, 0,0,
                      0,0,0,0,0, 0,0,0,0, 0,0);
        vecs[1]  = mk(1,32'h100,0,0,0,0,0, 1,32'hDEADBEEF,
                      1,0,32'h100,0,4'hF, 1,32'hDEADBEEF,0,0, 1,0);
        vecs[2]  = mk(0,0,0,0,0,0,0, 0,0,
                      0,0,0,0,0, 0,0,0,0, 0,0);
        vecs[3]  = mk(0,0,1,1,32'h2004,32'h12345678,4'b0011, 0,0,
                      0,0,0,0,0, 0,0,0,0, 0,0);
        vecs[4]  = mk(0,0,1,1,32'h2004,32'h12345678,4'b0011, 0,0,
                      1,1,32'h2004,32'h12345678,4'b0011, 0,0,0,0, 1,1);
        vecs[5]  = vecs[4];
        vecs[6]  = mk(0,0,1,1,32'h2004,32'h12345678,4'b0011, 1,32'hAAAA5555,
                      1,1,32'h2004,32'h12345678,4'b0011, 0,0,1,32'hAAAA5555, 1,1);
        vecs[7]  = vecs[2];
        vecs[8]  = mk(0,0,1,0,32'h40,0,4'hF, 0,0,
                      0,0,0,0,0, 0,0,0,0, 0,0);
        vecs[9]  = mk(0,0,1,0,32'h40,0,4'hF, 0,0,
                      1,0,32'h40,0,4'hF, 0,0,0,0, 1,1);
        vecs[10] = mk(0,0,0,0,32'h999,32'h55555555,4'h1, 0,0,
                      1,0,32'h40,0,4'hF, 0,0,0,0, 1,1);
        vecs[11] = mk(0,0,0,0,32'h999,32'h55555555,4'h1, 1,32'h0BADF00D,
                      1,0,32'h40,0,4'hF, 0,0,1,32'h0BADF00D, 1,1);
        vecs[12] = mk(0,0,0,0,0,0,0, 1,32'h12341234,
                      0,0,0,0,0, 0,0,0,0, 0,0);

        // Reset values
        tick();
        @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_gsel", grant_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].i_req, vecs[i].i_addr, vecs[i].d_req, vecs[i].d_we,
                  vecs[i].d_addr, vecs[i].d_wdata, vecs[i].d_be,
                  vecs[i].m_ack, vecs[i].m_rdata);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_gsel", i), grant_sel, vecs[i].e_gsel);
            chk($sformatf("vec%0d_m_req", i), m_req, vecs[i].e_m_req);
            chk($sformatf("vec%0d_i_ack", i), i_ack, vecs[i].e_i_ack);
            chk($sformatf("vec%0d_i_rdata", i), i_rdata, vecs[i].e_i_rdata);
            chk($sformatf("vec%0d_d_ack", i), d_ack, vecs[i].e_d_ack);
            chk($sformatf("vec%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            if (vecs[i].e_m_req) begin
                chk($sformatf("vec%0d_m_we", i), m_we, vecs[i].e_m_we);
                chk($sformatf("vec%0d_m_addr", i), m_addr, vecs[i].e_m_addr);
                chk($sformatf("vec%0d_m_wdata", i), m_wdata, vecs[i].e_m_wdata);
                chk($sformatf("vec%0d_m_be", i), m_be, vecs[i].e_m_be);
            end
            tick();
        end

        // Contest: both held, m_ack immediate; one IDLE cycle between grants
`ifdef ARB_ROUND_ROBIN_EN
        exp_d[0] = 1; exp_d[1] = 0; exp_d[2] = 1; exp_d[3] = 0;
`else
        exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 1; exp_d[3] = 1;
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h1000, 1, 0, 32'h2000, 0, 4'hF, 1, 32'hC0DE0000 + k);
            @(negedge clk);
            chk($sformatf("contest%0d_idle_busy", k), busy, 0);
            chk($sformatf("contest%0d_idle_ack", k), {i_ack, d_ack}, 0);
            tick();
            @(negedge clk);
            chk($sformatf("contest%0d_gsel", k), grant_sel, exp_d[k]);
            chk($sformatf("contest%0d_m_addr", k), m_addr, exp_d[k] ? 32'h2000 : 32'h1000);
            chk($sformatf("contest%0d_d_ack", k), d_ack, exp_d[k]);
            chk($sformatf("contest%0d_i_ack", k), i_ack, !exp_d[k]);
            tick();
        end
        drive(1, 32'h1000, 0, 0, 32'h2000, 0, 4'hF, 1, 32'h5A5A5A5A);
        @(negedge clk);
        chk("contest_drop_idle", busy, 0);
        tick();
        @(negedge clk);
        chk("contest_drop_gsel", grant_sel, 0);
        chk("contest_drop_i_ack", i_ack, 1);
        chk("contest_drop_i_rdata", i_rdata, 32'h5A5A5A5A);
        tick();

        // Reset in the middle of a fetch grant
        do_reset();
        drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rstmid_idle_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("rstmid_grant_busy", busy, 1);
        chk("rstmid_grant_m_req", m_req, 1);
        chk("rstmid_grant_gsel", grant_sel, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_rst_i_ack", i_ack, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF0000);
        @(negedge clk);
        chk("rstmid_after_m_req", m_req, 0);
        chk("rstmid_after_busy", busy, 0);
        chk("rstmid_after_gsel", grant_sel, 0);
        chk("rstmid_after_i_ack", i_ack, 0);
        tick();
        @(negedge clk);
        chk("rstmid_late_ack", {i_ack, d_ack}, 0);
        tick();

        // Randomized run against the reference model
        do_reset();
        mdl_busy   = 1'b0;
        mdl_last_d = 1'b0;
        mdl_own_d  = 1'b0;
        mdl_we     = 1'b0;
        mdl_addr   = '0;
        mdl_wdata  = '0;
        mdl_be     = '0;
        for (int c = 0; c < 3000; c++) begin
            rnd_req_i = ($urandom_range(0, 99) < 55);
            rst = ($urandom_range(0, 199) == 0);
            drive(rnd_req_i, $urandom, ($urandom_range(0, 99) < 55), $urandom_range(0, 1),
                  $urandom, $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 40), $urandom);
            @(negedge clk);
            mdl_check();
            mdl_step();
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
